case_1_prod_accum: RTL
======================

CASE_1_PROD_ACCUM -- requirements
Module: case_1_prod_accum

Interface
REQ-001 Parameters SHALL be: DIN_WIDTH, default 10, signed product width; DOUT_WIDTH, default 12, signed result width; LEN, default 8, terms per result (2..256).
REQ-002 Port ap_clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-003 Port ap_rst, input, 1, reset; it SHALL be synchronous and active-high.
REQ-004 Port in_din, input, DIN_WIDTH, signed product from the upstream multiplier.
REQ-005 Port in_vld, input, 1, in_din valid.
REQ-006 Port in_last, input, 1, qualifies in_din as the final term of the group (early termination).
REQ-007 Port in_rdy, output, 1, block accepts a term this cycle.
REQ-008 Port out_dout, output, DOUT_WIDTH, saturated signed sum.
REQ-009 Port out_cnt, output, 9, number of terms in out_dout.
REQ-010 Port out_sat, output, 1, out_dout was clipped.
REQ-011 Port out_vld, input-side consumer valid; output, 1.
REQ-012 Port out_rdy, input, 1, consumer accepts the result.

Function
REQ-013 A term SHALL be accepted exactly on cycles where in_vld && in_rdy.
REQ-014 The FSM SHALL have states IDLE, ACC and HOLD.
REQ-015 In IDLE and ACC, in_rdy SHALL be 1; in HOLD, in_rdy SHALL be 0.
REQ-016 IDLE -> ACC on an accepted term that is not the last term; IDLE -> HOLD on an accepted last term.
REQ-017 ACC -> HOLD on an accepted term that is the last term; otherwise stay in ACC.
REQ-018 The last term SHALL be in_last=1, or the accept that brings the term count to LEN, whichever comes first.
REQ-019 HOLD -> IDLE on out_vld && out_rdy; otherwise stay in HOLD.
REQ-020 Internal accumulator width SHALL be DIN_WIDTH+clog2(LEN) signed; operands sign-extended; no internal overflow possible.
REQ-021 The first accepted term of a group SHALL load the accumulator, not add to the stale value.
REQ-022 Latency: last term accepted at edge t gives out_vld=1 with valid out_dout/out_cnt/out_sat after edge t (same registered cycle as HOLD entry).
REQ-023 out_dout SHALL equal the sum clamped to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; out_sat=1 iff clamping occurred.
REQ-024 out_vld SHALL be 1 only in HOLD; out_dout, out_cnt and out_sat SHALL remain stable while out_vld && !out_rdy.
REQ-025 in_vld with in_rdy=0 (HOLD) SHALL have no effect; upstream holds data.
REQ-026 Maximum throughput SHALL be one result per count+1 cycles (one HOLD cycle minimum).
REQ-027 out_cnt SHALL wrap-protect: count never exceeds LEN.

Reset
REQ-028 When ap_rst=1 at an edge: state=IDLE, accumulator=0, count=0, out_dout=0, out_cnt=0, out_sat=0, out_vld=0, in_rdy=0 during reset.
REQ-029 Reset mid-group or in HOLD SHALL discard the partial/pending result without emitting it.
REQ-030 in_rdy SHALL become 1 on the first cycle after ap_rst deasserts.

Structure
REQ-031 FSM state encoding and the saturation-bound constants SHALL live in shared package case_1_pkg.
REQ-032 Saturation SHALL be a combinational sub-module case_1_sat_clip (wide signed in, DOUT_WIDTH out, sat flag); all else flat.

Verification (DIN_WIDTH=10, DOUT_WIDTH=12, LEN=8)
REQ-033 Terms 1..8, out_rdy=1 -> out_dout=36, out_cnt=8, out_sat=0, out_vld one cycle after 8th accept.
REQ-034 8 x +511 -> out_dout=2047, out_sat=1; 8 x -512 -> out_dout=-2048, out_sat=1.
REQ-035 Terms 5,-2,7 with in_last on third -> out_dout=10, out_cnt=3; next group starts fresh (terms 1,1 last -> 2).
REQ-036 out_rdy=0 for 5 cycles in HOLD while in_vld=1 -> outputs stable, in_rdy=0, no term consumed; releases on out_rdy=1.
REQ-037 ap_rst asserted after 4 accepted terms -> no out_vld, next group of 1..8 yields 36.

Source files
------------

// File: rtl/case_1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : case_1_pkg
// Description : Shared FSM state encoding and saturation-bound helpers for
//               the product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package case_1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int c_bound_w = 64;

    // Largest value representable in a signed word of the given width
    function automatic logic signed [c_bound_w-1:0] sat_hi(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed word of the given width
    function automatic logic signed [c_bound_w-1:0] sat_lo(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/case_1_sat_clip.sv
`default_nettype none
// ============================================================================
// Module      : case_1_sat_clip
// Description : Combinational signed clamp from a wide sum to OUT_WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
module case_1_sat_clip
    import case_1_pkg::*;
#(
    parameter int IN_WIDTH  = 13,
    parameter int OUT_WIDTH = 12
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        sat
);

    generate
        if (IN_WIDTH > OUT_WIDTH) begin : g_clip
            localparam logic signed [IN_WIDTH-1:0] c_hi = IN_WIDTH'(sat_hi(OUT_WIDTH));
            localparam logic signed [IN_WIDTH-1:0] c_lo = IN_WIDTH'(sat_lo(OUT_WIDTH));

            always_comb begin
                dout = din[OUT_WIDTH-1:0];
                sat  = 1'b0;
                if (din > c_hi) begin
                    dout = c_hi[OUT_WIDTH-1:0];
                    sat  = 1'b1;
                end else if (din < c_lo) begin
                    dout = c_lo[OUT_WIDTH-1:0];
                    sat  = 1'b1;
                end
            end
        end else begin : g_pass
            // Output is at least as wide as the input: clipping cannot occur
            assign dout = OUT_WIDTH'(din);
            assign sat  = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/case_1_prod_accum.sv
`default_nettype none
// ============================================================================
// Module      : case_1_prod_accum
// Description : Accumulates signed products into saturated group sums, with
//               early termination on in_last and a ready/valid result port.
// Revision    : 1.0 - initial release
// ============================================================================
module case_1_prod_accum
    import case_1_pkg::*;
#(
    parameter int DIN_WIDTH  = 10,
    parameter int DOUT_WIDTH = 12,
    parameter int LEN        = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic signed [DIN_WIDTH-1:0]  in_din,
    input  logic                         in_vld,
    input  logic                         in_last,
    output logic                         in_rdy,
    output logic signed [DOUT_WIDTH-1:0] out_dout,
    output logic [8:0]                   out_cnt,
    output logic                         out_sat,
    output logic                         out_vld,
    input  logic                         out_rdy
);

    localparam int c_acc_w = DIN_WIDTH + $clog2(LEN);

    state_t                       r_state;
    state_t                       w_state_next;
    logic signed [c_acc_w-1:0]    r_acc;
    logic [8:0]                   r_cnt;
    logic                         w_accept;
    logic                         w_last;
    logic signed [c_acc_w-1:0]    w_base;
    logic signed [c_acc_w-1:0]    w_sum;
    logic [8:0]                   w_cnt_next;
    logic signed [DOUT_WIDTH-1:0] w_clip;
    logic                         w_sat;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_rdy       = !ap_rst && (r_state != ST_HOLD);
        out_vld      = (r_state == ST_HOLD);
        w_accept     = in_vld && in_rdy;
        // First term of a group loads rather than adding to the stale sum
        w_base       = (r_state == ST_IDLE) ? '0 : r_acc;
        w_sum        = w_base + c_acc_w'(in_din);
        w_cnt_next   = (r_state == ST_IDLE) ? 9'd1 : r_cnt + 9'd1;
        w_last       = in_last || (w_cnt_next == 9'(LEN));
        case (r_state)
            ST_IDLE, ST_ACC: begin
                if (w_accept) begin
                    w_state_next = w_last ? ST_HOLD : ST_ACC;
                end
            end
            ST_HOLD: begin
                if (out_rdy) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    case_1_sat_clip #(
        .IN_WIDTH  (c_acc_w),
        .OUT_WIDTH (DOUT_WIDTH)
    ) u_sat_clip (
        .din  (w_sum),
        .dout (w_clip),
        .sat  (w_sat)
    );

    // Result registers load only with the final term, so they hold through HOLD
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            out_dout <= '0;
            out_cnt  <= '0;
            out_sat  <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_next;
            if (w_last) begin
                out_dout <= w_clip;
                out_cnt  <= w_cnt_next;
                out_sat  <= w_sat;
            end
        end
    end

endmodule
`default_nettype wire
